lsu_ctrl: RTL
=============

Name: lsu_ctrl

Overview:
- Load/store control stage directly upstream of the 64-bit data memory (word-addressed, combinational read, synchronous write).
- Accepts byte-addressed RISC-V load/store requests from the core with a valid/ready handshake.
- Sub-doubleword stores use a read-modify-write sequence.
- Load data is extracted and sign/zero-extended to 64 bits, then returned with a one-cycle response pulse.

Parameters:
- DATA_WIDTH, 64, memory word width; only 64 is supported.
- ADDR_WIDTH, 10, memory word-index width; selects from MEM_DEPTH words.
- REQ_ADDR_WIDTH, 64, width of the core byte address.

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_arst  input  1  asynchronous active-high reset
- i_req_valid  input  1  core request valid
- o_req_ready  output  1  block can accept a request; high only in IDLE
- i_req_we  input  1  1 = store, 0 = load
- i_req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = dword
- i_req_unsigned  input  1  zero-extend load (LBU/LHU/LWU)
- i_req_addr  input  REQ_ADDR_WIDTH  byte address
- i_req_wdata  input  DATA_WIDTH  store data, right-aligned
- o_rsp_valid  output  1  one-cycle completion pulse
- o_rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors
- o_rsp_err  output  1  misaligned access, qualified by o_rsp_valid
- o_mem_addr  output  ADDR_WIDTH  memory word index
- o_mem_write_en  output  1  memory write enable
- o_mem_write_data  output  DATA_WIDTH  merged write word
- i_mem_read_data  input  DATA_WIDTH  combinational memory read data

Behaviour:
- Reset (async, i_arst=1):
  - State goes to IDLE.
  - Outputs: o_req_ready=1, o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0, o_mem_write_en=0, o_mem_addr=0, o_mem_write_data=0.
  - All request registers cleared.
  - Reset mid-operation abandons the transaction: no write and no response occurs afterwards.
- Accept: on i_req_valid & o_req_ready, latch we, size, unsigned, addr, wdata (cycle 0). o_req_ready falls the next cycle.
- Address mapping:
  - Word index = addr[ADDR_WIDTH+2:3]; byte offset = addr[2:0].
  - Upper address bits are ignored (wrap-around).
- Misalignment: half needs offset[0]=0; word needs offset[1:0]=0; dword needs offset=0.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
  - IDLE -> RESP when the request is misaligned (see Optional Feature).
  - IDLE -> LOAD for a load.
  - IDLE -> WRITE for a dword store.
  - IDLE -> RMW_READ for a byte/half/word store.
  - LOAD: drive o_mem_addr, capture i_mem_read_data, -> RESP.
  - RMW_READ: drive o_mem_addr, capture the read word, -> WRITE.
  - WRITE: o_mem_write_en=1 for exactly one cycle, -> RESP.
    - o_mem_write_data = captured word with the sized bytes at the offset replaced by wdata's low bytes.
    - For a dword store, o_mem_write_data = wdata.
  - RESP: o_rsp_valid=1 for one cycle, -> IDLE.
- Latency from accept to o_rsp_valid: load 2, dword store 2, sub-dword store 3, misaligned 1.
- Back-to-back: a new request can be accepted in the cycle after RESP.
- Response data: no backpressure on responses; o_rsp_rdata holds its value until the next response.
- Load extraction:
  - data = read_word >> (offset*8), truncated to the size.
  - Sign-extended from bit 7/15/31 unless unsigned.
  - Dword loads ignore i_req_unsigned.
- o_mem_write_en is never high outside WRITE.
- o_mem_addr holds the latched index in every non-IDLE state.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests perform no memory access; RESP has o_rsp_err=1 and o_rsp_rdata=0.
- Undefined:
  - The offset is force-aligned down to the size boundary (addr bits cleared) and the access proceeds normally.
  - o_rsp_err is tied to 0.

Test Plan:
- Reset: assert i_arst mid-RMW (in RMW_READ) -> o_mem_write_en never pulses, o_rsp_valid=0, o_req_ready=1 after reset.
- Dword store then load: store addr 0x40, wdata 0x1122334455667788 -> write_en at cycle 1 to index 8, rsp at cycle 2. Load dword from 0x40 -> rdata 0x1122334455667788 at cycle 2.
- Byte store RMW: memory[8]=0x1122334455667788; SB addr 0x43, wdata 0xAB -> write_data 0x11223344AB667788 at cycle 2, rsp at cycle 3.
- Sign extension: memory[8]=0x00000000_8000FF80. LB addr 0x40 -> 0xFFFFFFFFFFFFFF80; LBU -> 0x80; LH addr 0x42 -> 0xFFFFFFFFFFFF8000; LW addr 0x40 -> 0xFFFFFFFF8000FF80; LWU -> 0x000000008000FF80.
- Misaligned LW addr 0x42:
  - With LSU_MISALIGN_TRAP_EN: rsp at cycle 1, err=1, no memory write.
  - Without: reads the word at offset 0.
- Handshake: i_req_valid held high for 3 back-to-back loads -> each accepted only when ready=1, exactly 3 rsp pulses, addresses wrap (addr 0x2040 maps to index 8 for ADDR_WIDTH=10).

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store control between the core and a 64-bit word-addressed data memory.
// Optional misalignment trap selected by `define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 10,
   parameter int REQ_ADDR_WIDTH = 64
) (
   input  logic                  i_clk,
   input  logic                  i_arst,
   input  logic                  i_req_valid,
   output logic                  o_req_ready,
   input  logic                  i_req_we,
   input  logic [1:0]            i_req_size,
   input  logic                  i_req_unsigned,
   input  logic [REQ_ADDR_WIDTH-1:0] i_req_addr,
   input  logic [DATA_WIDTH-1:0] i_req_wdata,
   output logic                  o_rsp_valid,
   output logic [DATA_WIDTH-1:0] o_rsp_rdata,
   output logic                  o_rsp_err,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic                  o_mem_write_en,
   output logic [DATA_WIDTH-1:0] o_mem_write_data,
   input  logic [DATA_WIDTH-1:0] i_mem_read_data
);

   typedef enum logic [2:0] {IDLE, LOAD, RMW_READ, WRITE, RESP} state_t;

   state_t                state;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [2:0]            req_off;
   logic [DATA_WIDTH-1:0] req_wdata;

   logic                  trap_hit;
   logic [2:0]            off_eff;
   logic                  unused_addr;

   // Bits above the word index are ignored so addresses wrap around the memory.
   assign unused_addr = ^i_req_addr[REQ_ADDR_WIDTH-1:ADDR_WIDTH+3];

   function automatic logic [DATA_WIDTH-1:0] load_extend(
      input logic [DATA_WIDTH-1:0] word,
      input logic [1:0]            size,
      input logic [2:0]            off,
      input logic                  uns
   );
      logic [DATA_WIDTH-1:0] sh;
      sh = word >> {off, 3'b000};
      case (size)
         2'd0:    load_extend = {{(DATA_WIDTH-8){sh[7] & ~uns}}, sh[7:0]};
         2'd1:    load_extend = {{(DATA_WIDTH-16){sh[15] & ~uns}}, sh[15:0]};
         2'd2:    load_extend = {{(DATA_WIDTH-32){sh[31] & ~uns}}, sh[31:0]};
         default: load_extend = sh;
      endcase
   endfunction

   function automatic logic [DATA_WIDTH-1:0] store_merge(
      input logic [DATA_WIDTH-1:0] word,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [1:0]            size,
      input logic [2:0]            off
   );
      logic [DATA_WIDTH-1:0] mask;
      case (size)
         2'd0:    mask = DATA_WIDTH'(8'hFF);
         2'd1:    mask = DATA_WIDTH'(16'hFFFF);
         2'd2:    mask = DATA_WIDTH'(32'hFFFF_FFFF);
         default: mask = '1;
      endcase
      mask        = mask << {off, 3'b000};
      store_merge = (word & ~mask) | ((wdata << {off, 3'b000}) & mask);
   endfunction

`ifdef LSU_MISALIGN_TRAP_EN
   function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd1:    is_misaligned = off[0];
         2'd2:    is_misaligned = |off[1:0];
         2'd3:    is_misaligned = |off;
         default: is_misaligned = 1'b0;
      endcase
   endfunction

   assign trap_hit = is_misaligned(i_req_size, i_req_addr[2:0]);
   assign off_eff  = i_req_addr[2:0];
`else
   function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'd1:    align_off = {off[2:1], 1'b0};
         2'd2:    align_off = {off[2], 2'b00};
         2'd3:    align_off = 3'b000;
         default: align_off = off;
      endcase
   endfunction

   assign trap_hit = 1'b0;
   assign off_eff  = align_off(i_req_size, i_req_addr[2:0]);
`endif

   always_ff @(posedge i_clk or posedge i_arst) begin
      if (i_arst) begin
         state            <= IDLE;
         req_size         <= '0;
         req_unsigned     <= 1'b0;
         req_off          <= '0;
         req_wdata        <= '0;
         o_req_ready      <= 1'b1;
         o_rsp_valid      <= 1'b0;
         o_rsp_rdata      <= '0;
         o_rsp_err        <= 1'b0;
         o_mem_addr       <= '0;
         o_mem_write_en   <= 1'b0;
         o_mem_write_data <= '0;
      end else begin
         o_rsp_valid    <= 1'b0;
         o_mem_write_en <= 1'b0;
         case (state)
            IDLE: begin
               if (i_req_valid) begin
                  req_size     <= i_req_size;
                  req_unsigned <= i_req_unsigned;
                  req_off      <= off_eff;
                  req_wdata    <= i_req_wdata;
                  o_mem_addr   <= i_req_addr[ADDR_WIDTH+2:3];
                  o_req_ready  <= 1'b0;
                  o_rsp_err    <= trap_hit;
                  if (trap_hit) begin
                     state       <= RESP;
                     o_rsp_valid <= 1'b1;
                     o_rsp_rdata <= '0;
                  end else if (!i_req_we) begin
                     state <= LOAD;
                  end else if (i_req_size == 2'd3) begin
                     state            <= WRITE;
                     o_mem_write_en   <= 1'b1;
                     o_mem_write_data <= i_req_wdata;
                  end else begin
                     state <= RMW_READ;
                  end
               end
            end
            LOAD: begin
               state       <= RESP;
               o_rsp_valid <= 1'b1;
               o_rsp_rdata <= load_extend(i_mem_read_data, req_size, req_off, req_unsigned);
            end
            RMW_READ: begin
               state            <= WRITE;
               o_mem_write_en   <= 1'b1;
               o_mem_write_data <= store_merge(i_mem_read_data, req_wdata, req_size, req_off);
            end
            WRITE: begin
               state       <= RESP;
               o_rsp_valid <= 1'b1;
               o_rsp_rdata <= '0;
            end
            RESP: begin
               state       <= IDLE;
               o_req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
